compressor_stream_arbiter: RTL and testbench
============================================

Name: compressor_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares one Compressor instance between NUM_SRC AXI-stream sources.
- Grants one source per packet and holds the grant until that packet's tlast beat completes.
- Muxes data, valid and last toward the Compressor and routes its tready back to the granted source only.
- Also drives the Compressor's wrt_en and reports the current owner for downstream result tagging.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- DATA_WIDTH, 256, stream beat width (32 bytes × 8 bits).
- GRANT_W, 1, grant index width; must equal ceil(log2(NUM_SRC)), minimum 1.
- MAX_BEATS, 64, beat limit per packet; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- cfg_enable  in  1  allows new grants; registered into wrt_en.
- s_tdata  in  NUM_SRC*DATA_WIDTH  source beats, flattened; source i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tlast  in  NUM_SRC  per-source end of packet.
- s_tready  out  NUM_SRC  per-source ready.
- m_tdata  out  DATA_WIDTH  beat to Compressor data_in.
- m_tvalid  out  1  to Compressor tvalid.
- m_tlast  out  1  to Compressor tlast.
- m_tready  in  1  from Compressor tready.
- wrt_en  out  1  to Compressor wrt_en.
- grant_valid  out  1  a source currently owns the Compressor.
- grant_idx  out  GRANT_W  index of the owning source.
- pkt_done  out  1  one-cycle pulse after a packet completes.
- err_trunc  out  1  one-cycle pulse when a packet is truncated (ARB_TIMEOUT_EN only).

Behaviour:
- Reset (reset=0 at a clk edge) forces:
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - grant_valid, pkt_done, err_trunc, wrt_en all 0.
  - s_tready all 0; m_tvalid and m_tlast 0; m_tdata 0.
- Reset mid-packet aborts the packet immediately. The Compressor sees a packet with no tlast; the system must also reset the Compressor.
- wrt_en <= cfg_enable each cycle, giving 1 cycle of latency.
- IDLE state:
  - Outputs: m_tvalid=0, s_tready all 0, m_tdata=0.
  - If cfg_enable=1 and any s_tvalid=1: grant the first requester found by searching rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - The grant is registered: grant_idx<=winner, grant_valid<=1, next state XFER.
  - Arbitration latency is 1 cycle; a source's first beat can transfer no earlier than the cycle after its s_tvalid is first sampled.
- XFER state, combinational path with zero datapath latency and no registering:
  - m_tdata, m_tvalid and m_tlast are driven from source g=grant_idx.
  - s_tready[g]=m_tready; all other s_tready=0.
- XFER handshake:
  - A beat transfers when m_tvalid & m_tready.
  - On a beat with m_tlast=1: next state IDLE, grant_valid<=0, rr_ptr<=(g+1) mod NUM_SRC, pkt_done<=1 for exactly one cycle.
  - Back-to-back packets always cost one IDLE bubble cycle.
- cfg_enable going low during XFER has no effect on the packet in flight; it completes, then no new grant is issued.
- A granted source that drops s_tvalid mid-packet keeps its grant; m_tvalid=0 until it resumes.
- m_tready low holds the beat; the arbiter adds no buffering and never drops data in XFER.
- Only one source is ever granted. Non-granted sources see s_tready=0 regardless of m_tready.
- If only one source requests, it is re-granted after each packet, with one bubble between packets.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Adds a beat counter, cleared on grant and incremented on each XFER handshake.
  - On the MAX_BEATS-th handshake without s_tlast: force m_tlast=1 on that beat, pulse err_trunc for one cycle, and enter state DROP.
  - DROP state: m_tvalid=0, s_tready[g]=1, and source beats are discarded until a beat with s_tlast=1 is accepted.
  - Then go to IDLE with rr_ptr advanced and pkt_done pulsed.
  - reset or a genuine tlast on the MAX_BEATS-th beat gives normal completion with no err_trunc.
- Not defined: no counter and no DROP state; err_trunc is tied to 0; packets are unbounded.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all s_tvalid=1 -> s_tready=00, m_tvalid=0, grant_valid=0, wrt_en=0. Release with cfg_enable=1 -> wrt_en=1 one cycle later.
- Single packet:
  - Stimulus: source 0 sends 6 beats (Ethernet/IPv4 header beat with [111:96]=16'h0008 and [143:128]=16'hdc05, then 5 beats of 0xBA98_FEDC…), with tlast on beat 6 and m_tready=1.
  - Required: grant_idx=0 one cycle after the first s_tvalid; m_tdata equals the source beats with no gaps; pkt_done pulses the cycle after beat 6.
- Contention:
  - Stimulus: sources 0 and 1 both request continuously, with 3-beat packets.
  - Required: grants alternate 0,1,0,1; one IDLE cycle between packets; s_tready[1]=0 whenever g=0.
- Backpressure:
  - Stimulus: during a 4-beat packet on source 1, toggle m_tready 1,0,0,1,1,0,1.
  - Required: exactly 4 handshakes; m_tdata stable while m_tready=0; s_tready[1] mirrors m_tready.
- Mid-packet events:
  - Stimulus: drop cfg_enable after beat 2 of a 5-beat packet -> packet completes and no further grant while source 0 keeps s_tvalid=1.
  - Stimulus: separately, assert reset=0 on beat 3 -> all outputs return to reset values the next cycle.
- ARB_TIMEOUT_EN with MAX_BEATS=4:
  - Stimulus: send a 7-beat packet.
  - Required: m_tlast=1 on beat 4; err_trunc pulses; beats 5-7 accepted with m_tvalid=0; pkt_done after beat 7; next grant proceeds normally.

Source files
------------

// File: rtl/compressor_stream_arbiter.sv
// compressor_stream_arbiter
//   Packet-level round-robin arbiter that shares one Compressor between
//   NUM_SRC AXI-stream sources. A source keeps the grant from the first beat
//   of a packet until its tlast beat. The datapath is combinational.
//   Optional macro ARB_TIMEOUT_EN caps packets at MAX_BEATS beats. When a
//   packet is cut, the tail of that packet is discarded in a DROP state.
module compressor_stream_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int GRANT_W    = 1,
  parameter int MAX_BEATS  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic                          wrt_en,
  output logic                          grant_valid,
  output logic [GRANT_W-1:0]            grant_idx,
  output logic                          pkt_done,
  output logic                          err_trunc
);

  localparam int GW_EXP = ($clog2(NUM_SRC) < 1) ? 1 : $clog2(NUM_SRC);

  // Elaboration-time parameter sanity checks.
  if ((GRANT_W != GW_EXP) || (NUM_SRC < 2) || (NUM_SRC > 8) || (MAX_BEATS < 1)) begin : g_bad_param
    $error("compressor_stream_arbiter: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic               pkt_done_q, pkt_done_d;
  logic               wrt_en_q;

  logic [DATA_WIDTH-1:0] src_arr_s [NUM_SRC];
  logic [DATA_WIDTH-1:0] src_data_s;
  logic                  src_valid_s;
  logic                  src_last_s;
  logic [GRANT_W-1:0]    win_idx_s;
  logic                  win_found_s;
  logic [GRANT_W-1:0]    cand_s;
  logic [GRANT_W-1:0]    next_ptr_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_trunc_q, err_trunc_d;
  logic             beat_cap_s;
  assign beat_cap_s = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  assign err_trunc  = err_trunc_q;
`else
  assign err_trunc  = 1'b0;
`endif

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_arr_s[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign src_data_s  = src_arr_s[grant_idx_q];
  assign src_valid_s = s_tvalid[grant_idx_q];
  assign src_last_s  = s_tlast[grant_idx_q];
  assign next_ptr_s  = (grant_idx_q == GRANT_W'(NUM_SRC - 1)) ? {GRANT_W{1'b0}}
                                                              : grant_idx_q + GRANT_W'(1);

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign pkt_done    = pkt_done_q;
  assign wrt_en      = wrt_en_q;

  // Round-robin search: first requester starting at rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    win_idx_s   = rr_ptr_q;
    win_found_s = 1'b0;
    cand_s      = rr_ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_s = GRANT_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!win_found_s && s_tvalid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic plus the combinational stream mux toward the Compressor.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    pkt_done_d    = 1'b0;
    s_tready      = {NUM_SRC{1'b0}};
    m_tdata       = {DATA_WIDTH{1'b0}};
    m_tvalid      = 1'b0;
    m_tlast       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    beat_cnt_d    = beat_cnt_q;
    err_trunc_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable && win_found_s) begin
          state_d       = ST_XFER;
          grant_idx_d   = win_idx_s;
          grant_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          beat_cnt_d    = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        m_tdata               = src_data_s;
        m_tvalid              = src_valid_s;
        s_tready[grant_idx_q] = m_tready;
`ifdef ARB_TIMEOUT_EN
        m_tlast               = src_last_s | beat_cap_s;
`else
        m_tlast               = src_last_s;
`endif
        if (src_valid_s && m_tready) begin
`ifdef ARB_TIMEOUT_EN
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
`endif
          if (src_last_s) begin
            state_d       = ST_IDLE;
            grant_valid_d = 1'b0;
            rr_ptr_d      = next_ptr_s;
            pkt_done_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
          end else if (beat_cap_s) begin
            // Cut the packet: Compressor sees tlast now, the tail is discarded.
            state_d     = ST_DROP;
            err_trunc_d = 1'b1;
`endif
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
`ifdef ARB_TIMEOUT_EN
      ST_DROP: begin
        s_tready[grant_idx_q] = 1'b1;
        if (src_valid_s && src_last_s) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          rr_ptr_d      = next_ptr_s;
          pkt_done_d    = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
`endif
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= {GRANT_W{1'b0}};
      grant_idx_q   <= {GRANT_W{1'b0}};
      grant_valid_q <= 1'b0;
      pkt_done_q    <= 1'b0;
      wrt_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      pkt_done_q    <= pkt_done_d;
      wrt_en_q      <= cfg_enable;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Beat counter and truncation pulse for the packet-length cap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt_q  <= {CNT_W{1'b0}};
      err_trunc_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      err_trunc_q <= err_trunc_d;
    end
  end
`endif

endmodule

// File: tb/tb_compressor_stream_arbiter.sv
// Directed bench for compressor_stream_arbiter (NUM_SRC=2, DATA_WIDTH=256).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_compressor_stream_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_enable;
  logic [255:0] d0, d1;
  logic [511:0] s_tdata;
  logic [1:0]   s_tvalid, s_tlast, s_tready;
  logic [255:0] m_tdata;
  logic         m_tvalid, m_tlast, m_tready;
  logic         wrt_en, grant_valid, pkt_done, err_trunc;
  logic [0:0]   grant_idx;

  int n_checks = 0;
  int n_errors = 0;

  assign s_tdata = {d1, d0};

  always #5 clk = ~clk;

  compressor_stream_arbiter #(
    .NUM_SRC(2), .DATA_WIDTH(256), .GRANT_W(1), .MAX_BEATS(4)
  ) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .wrt_en(wrt_en), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .pkt_done(pkt_done), .err_trunc(err_trunc)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] word(input int s, input int b);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(s * 256 + b);
    return {8{w}};
  endfunction

  logic [255:0] hdr;
  logic [0:6]   bp_pat = 7'b1001101;
  int           bp_beat [7] = '{0, 1, 1, 1, 2, 3, 3};
  int           hs, cnt0, cnt1, ph, g;
  logic [1:0]   hs_prev;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hdr = 256'd0;
    hdr[111:96]  = 16'h0008;
    hdr[143:128] = 16'hdc05;

    // ---------------- reset ----------------
    reset = 1'b0; cfg_enable = 1'b0; s_tvalid = 2'b11; s_tlast = 2'b00;
    d0 = word(0, 0); d1 = word(1, 0); m_tready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_s_tready", s_tready, 256'd0);
    chk("rst_m_tvalid", m_tvalid, 256'd0);
    chk("rst_m_tdata", m_tdata, 256'd0);
    chk("rst_grant_valid", grant_valid, 256'd0);
    chk("rst_grant_idx", grant_idx, 256'd0);
    chk("rst_wrt_en", wrt_en, 256'd0);
    chk("rst_pkt_done", pkt_done, 256'd0);
    @(negedge clk); reset = 1'b1; cfg_enable = 1'b1; s_tvalid = 2'b00; #1;
    chk("wrt_en_latency0", wrt_en, 256'd0);
    @(negedge clk); #1;
    chk("wrt_en_latency1", wrt_en, 256'd1);
    chk("idle_no_grant", grant_valid, 256'd0);

    // ---------------- single packet, source 0, 6 beats ----------------
    @(negedge clk); s_tvalid = 2'b01; d0 = hdr; s_tlast = 2'b00; m_tready = 1'b1; #1;
    chk("sp_idle_m_tvalid", m_tvalid, 256'd0);
    chk("sp_idle_s_tready", s_tready, 256'd0);
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      d0 = (b == 0) ? hdr : (256'({8{32'hBA98_FEDC}}) ^ 256'(b));
      s_tlast = (b == 5) ? 2'b01 : 2'b00; #1;
      chk("sp_grant_valid", grant_valid, 256'd1);
      chk("sp_grant_idx", grant_idx, 256'd0);
      chk("sp_m_tvalid", m_tvalid, 256'd1);
      chk("sp_m_tdata", m_tdata, (b == 0) ? hdr : (256'({8{32'hBA98_FEDC}}) ^ 256'(b)));
      chk("sp_m_tlast", m_tlast, 256'(b == 5));
      chk("sp_s_tready", s_tready, 256'd1);
      chk("sp_pkt_done_low", pkt_done, 256'd0);
    end
    @(negedge clk); s_tvalid = 2'b00; s_tlast = 2'b00; #1;
    chk("sp_pkt_done", pkt_done, 256'd1);
    chk("sp_release", grant_valid, 256'd0);
    chk("sp_idle_m_tvalid2", m_tvalid, 256'd0);
    @(negedge clk); #1;
    chk("sp_pkt_done_pulse", pkt_done, 256'd0);

    // ---------------- backpressure, source 1, 4 beats ----------------
    @(negedge clk); s_tvalid = 2'b10; d1 = word(1, 0); s_tlast = 2'b00; m_tready = 1'b1; #1;
    chk("bp_idle_s_tready", s_tready, 256'd0);
    hs = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      m_tready = bp_pat[k];
      d1 = word(1, bp_beat[k]);
      s_tlast = (bp_beat[k] == 3) ? 2'b10 : 2'b00; #1;
      chk("bp_grant_idx", grant_idx, 256'd1);
      chk("bp_s_tready", s_tready, 256'({bp_pat[k], 1'b0}));
      chk("bp_m_tdata", m_tdata, word(1, bp_beat[k]));
      chk("bp_m_tvalid", m_tvalid, 256'd1);
      if (m_tvalid && m_tready) hs++;
    end
    @(negedge clk); s_tvalid = 2'b00; s_tlast = 2'b00; m_tready = 1'b1; #1;
    chk("bp_handshakes", 256'(hs), 256'd4);
    chk("bp_pkt_done", pkt_done, 256'd1);
    chk("bp_release", grant_valid, 256'd0);
    @(negedge clk); #1;

    // ---------------- contention, 3-beat packets ----------------
    cnt0 = 0; cnt1 = 0; hs_prev = 2'b00;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (hs_prev[0]) cnt0 = (cnt0 + 1) % 3;
      if (hs_prev[1]) cnt1 = (cnt1 + 1) % 3;
      s_tvalid = 2'b11; d0 = word(0, cnt0); d1 = word(1, cnt1);
      s_tlast = {(cnt1 == 2), (cnt0 == 2)}; m_tready = 1'b1; #1;
      ph = c % 4;
      g  = (c / 4) % 2;
      if (ph == 0) begin
        chk("ct_bubble_gv", grant_valid, 256'd0);
        chk("ct_bubble_s_tready", s_tready, 256'd0);
        if (c > 0) chk("ct_pkt_done", pkt_done, 256'd1);
      end else begin
        chk("ct_gv", grant_valid, 256'd1);
        chk("ct_grant_idx", grant_idx, 256'(g));
        chk("ct_s_tready", s_tready, (g == 1) ? 256'd2 : 256'd1);
        chk("ct_m_tdata", m_tdata, word(g, ph - 1));
        chk("ct_m_tlast", m_tlast, 256'(ph == 3));
      end
      hs_prev = s_tready & s_tvalid;
    end
    @(negedge clk); s_tvalid = 2'b00; s_tlast = 2'b00; #1;
    chk("ct_last_pkt_done", pkt_done, 256'd1);
    chk("ct_release", grant_valid, 256'd0);

    // ---------------- cfg_enable drop mid-packet ----------------
    @(negedge clk); s_tvalid = 2'b01; d0 = word(0, 0); s_tlast = 2'b00; cfg_enable = 1'b1; #1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      d0 = word(0, b); s_tlast = (b == 4) ? 2'b01 : 2'b00;
      if (b == 2) cfg_enable = 1'b0;
      #1;
      chk("cd_m_tvalid", m_tvalid, 256'd1);
      chk("cd_m_tdata", m_tdata, word(0, b));
      chk("cd_gv", grant_valid, 256'd1);
      if (b == 3) chk("cd_wrt_en", wrt_en, 256'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); d0 = word(0, 7); s_tlast = 2'b00; #1;
      chk("cd_no_grant", grant_valid, 256'd0);
      chk("cd_s_tready", s_tready, 256'd0);
      chk("cd_m_tvalid_low", m_tvalid, 256'd0);
      chk("cd_pkt_done", pkt_done, 256'(i == 0));
    end

    // ---------------- reset during beat 3 ----------------
    @(negedge clk); cfg_enable = 1'b1; d0 = word(0, 0); #1;
    chk("mr_idle", grant_valid, 256'd0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); d0 = word(0, b);
      if (b == 2) reset = 1'b0;
      #1;
      chk("mr_m_tvalid", m_tvalid, 256'd1);
      chk("mr_m_tdata", m_tdata, word(0, b));
    end
    @(negedge clk); #1;
    chk("mr_s_tready", s_tready, 256'd0);
    chk("mr_m_tvalid_rst", m_tvalid, 256'd0);
    chk("mr_m_tlast", m_tlast, 256'd0);
    chk("mr_m_tdata_rst", m_tdata, 256'd0);
    chk("mr_gv", grant_valid, 256'd0);
    chk("mr_grant_idx", grant_idx, 256'd0);
    chk("mr_wrt_en", wrt_en, 256'd0);
    chk("mr_pkt_done", pkt_done, 256'd0);
    chk("mr_err_trunc", err_trunc, 256'd0);
    @(negedge clk); reset = 1'b1; s_tvalid = 2'b00; cfg_enable = 1'b1; #1;
    @(negedge clk); #1;

    // ---------------- 7-beat packet (cap at 4 beats when enabled) ----------------
    @(negedge clk); s_tvalid = 2'b01; d0 = word(0, 0); s_tlast = 2'b00; m_tready = 1'b1; #1;
    for (int b = 0; b < 7; b++) begin
      @(negedge clk); d0 = word(0, b); s_tlast = (b == 6) ? 2'b01 : 2'b00; #1;
`ifdef ARB_TIMEOUT_EN
      if (b < 4) begin
        chk("to_m_tvalid", m_tvalid, 256'd1);
        chk("to_m_tlast", m_tlast, 256'(b == 3));
        chk("to_m_tdata", m_tdata, word(0, b));
      end else begin
        chk("to_drop_m_tvalid", m_tvalid, 256'd0);
        chk("to_drop_s_tready", s_tready, 256'd1);
        chk("to_err_trunc", err_trunc, 256'(b == 4));
        chk("to_drop_gv", grant_valid, 256'd1);
      end
`else
      chk("lp_m_tvalid", m_tvalid, 256'd1);
      chk("lp_m_tlast", m_tlast, 256'(b == 6));
      chk("lp_m_tdata", m_tdata, word(0, b));
      chk("lp_err_trunc", err_trunc, 256'd0);
`endif
    end
    @(negedge clk); d0 = word(0, 0); s_tlast = 2'b00; #1;
    chk("lp_pkt_done", pkt_done, 256'd1);
    chk("lp_err_trunc_after", err_trunc, 256'd0);
    chk("lp_release", grant_valid, 256'd0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); d0 = word(0, b); s_tlast = (b == 1) ? 2'b01 : 2'b00; #1;
      chk("np_gv", grant_valid, 256'd1);
      chk("np_m_tvalid", m_tvalid, 256'd1);
      chk("np_m_tlast", m_tlast, 256'(b == 1));
      chk("np_m_tdata", m_tdata, word(0, b));
    end
    @(negedge clk); s_tvalid = 2'b00; s_tlast = 2'b00; #1;
    chk("np_pkt_done", pkt_done, 256'd1);
    chk("np_err_trunc", err_trunc, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
